shift_deserializer: RTL and testbench

Serial-in, parallel-out receiver that assembles a framed 1-bit stream into N-bit words, with selectable MSB-first (left-shift) or LSB-first (right-shift) bit order. It is the receiving end for words serialized by the team's shift-register datapath. Completed words go to a one-entry output holding register with a valid/ready handshake, and lost words are flagged as overrun.

---
 rtl/shift_deserializer_if.sv | 25 ++
 rtl/shift_deserializer.sv | 134 +++++++++++++
 tb/tb_shift_deserializer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/shift_deserializer_if.sv
// Serial-in / parallel-out handshake bundle for shift_deserializer.
// master = bit source and word consumer, slave = the deserializer.
interface shift_deserializer_if #(
  parameter int N = 8
);
  logic         sin_valid;
  logic         sin_data;
  logic         sin_start;
  logic         msb_first;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         overrun;
  logic         parity_err;

  modport master (
    output sin_valid, sin_data, sin_start, msb_first, out_ready,
    input  out_data, out_valid, overrun, parity_err
  );

  modport slave (
    input  sin_valid, sin_data, sin_start, msb_first, out_ready,
    output out_data, out_valid, overrun, parity_err
  );
endinterface

// File: rtl/shift_deserializer.sv
// Framed 1-bit stream to N-bit words, MSB- or LSB-first, one-entry output with overrun flag.
// Optional even-parity trailer bit per frame: define SHIFT_DESERIALIZER_PARITY_EN.
module shift_deserializer #(
  parameter int N = 8
) (
  input logic                 clk,
  input logic                 rst,
  shift_deserializer_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t       state, state_n;
  logic [N-1:0] sr, sr_n;
  logic [N-1:0] out_data, out_data_n;
  logic [N-1:0] shifted, word;
  logic [CW-1:0] cnt, cnt_n;
  logic         mode, mode_n;
  logic         out_valid, out_valid_n;
  logic         overrun, overrun_n;
  logic         start_acc, order, complete, word_ok;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  logic         par, par_n;
  logic         perr, perr_n;
`endif

  assign start_acc = bus.sin_valid & bus.sin_start;
  // A start bit shifts in using the order being latched with it, not the stale mode.
  assign order     = start_acc ? bus.msb_first : mode;
  assign shifted   = order ? {sr[N-2:0], bus.sin_data} : {bus.sin_data, sr[N-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      mode      <= 1'b1;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      par       <= 1'b0;
      perr      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      mode      <= mode_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      overrun   <= overrun_n;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      par       <= par_n;
      perr      <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    sr_n        = sr;
    cnt_n       = cnt;
    mode_n      = mode;
    out_data_n  = out_data;
    out_valid_n = out_valid;
    overrun_n   = overrun;
    complete    = 1'b0;
    word_ok     = 1'b1;
    word        = shifted;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    par_n       = par;
    perr_n      = 1'b0;
`endif

    if (out_valid && bus.out_ready) out_valid_n = 1'b0;

    if (start_acc) begin
      // Start bit is accepted in either state; a partial frame is dropped silently.
      mode_n  = bus.msb_first;
      sr_n    = shifted;
      cnt_n   = CW'(1);
      state_n = RECV;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      par_n   = bus.sin_data;
`endif
    end else if (state == RECV && bus.sin_valid) begin
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      if (cnt == CW'(N)) begin
        complete = 1'b1;
        word     = sr;
        word_ok  = ~(par ^ bus.sin_data);
        cnt_n    = '0;
        par_n    = 1'b0;
      end else begin
        sr_n  = shifted;
        par_n = par ^ bus.sin_data;
        cnt_n = cnt + CW'(1);
      end
`else
      sr_n = shifted;
      if (cnt == CW'(N - 1)) begin
        complete = 1'b1;
        cnt_n    = '0;
      end else begin
        cnt_n = cnt + CW'(1);
      end
`endif
    end

    if (complete) begin
      if (!word_ok) begin
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        perr_n = 1'b1;
`endif
      end else if (!out_valid || bus.out_ready) begin
        out_data_n  = word;
        out_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  assign bus.out_data  = out_data;
  assign bus.out_valid = out_valid;
  assign bus.overrun   = overrun;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  assign bus.parity_err = perr;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer: expected words queued at stimulus, checked on handshake.
module tb_shift_deserializer;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_deserializer_if #(.N(N)) bus ();
  shift_deserializer #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [N-1:0] expq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer happens at the next rising edge when valid & ready are seen here.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) check("unexpected_word_q", expq.size(), 1);
      else check("out_data", bus.out_data, expq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d, input logic s, input logic m);
    bus.sin_valid = 1'b1;
    bus.sin_data  = d;
    bus.sin_start = s;
    bus.msb_first = m;
    tick();
    bus.sin_valid = 1'b0;
    bus.sin_start = 1'b0;
    bus.sin_data  = 1'($urandom_range(1));
    bus.msb_first = 1'($urandom_range(1));
  endtask

  task automatic send_word(input logic [N-1:0] w, input logic m, input logic with_start,
                           input int unsigned gap, input logic bad_par, input logic ready_last);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(gap)) begin
        bus.sin_start = 1'($urandom_range(1));
        tick();
      end
      bus.sin_start = 1'b0;
`ifndef SHIFT_DESERIALIZER_PARITY_EN
      if (ready_last && i == N - 1) bus.out_ready = 1'b1;
`endif
      send_bit(m ? w[N-1-i] : w[i], with_start && i == 0, m);
    end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    if (ready_last) bus.out_ready = 1'b1;
    send_bit((^w) ^ bad_par, 1'b0, m);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] w;
    logic         m;
    logic         st;

    bus.sin_valid = 1'b0;
    bus.sin_data  = 1'b0;
    bus.sin_start = 1'b0;
    bus.msb_first = 1'b0;
    bus.out_ready = 1'b0;
    m = 1'b1;

    rst = 1'b0;
    repeat (3) tick();
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_parity_err", bus.parity_err, 0);
    rst = 1'b1;
    tick();

    // MSB-first word and one-stage latency
    bus.out_ready = 1'b1;
    expq.push_back(8'hB4);
    send_word(8'hB4, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    check("msb_valid", bus.out_valid, 1);
    check("msb_data", bus.out_data, 8'hB4);
    tick();
    check("valid_clear", bus.out_valid, 0);

    // LSB-first: same on-wire sequence 1,0,1,1,0,1,0,0
    expq.push_back(8'h2D);
    send_word(8'h2D, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    check("lsb_data", bus.out_data, 8'h2D);
    tick();

    // Random words, some continuing without sin_start, some with stall gaps
    for (int k = 0; k < 6; k++) begin
      w  = N'($urandom);
      st = (k == 0) ? 1'b1 : 1'($urandom_range(1));
      if (st) m = 1'($urandom_range(1));
      expq.push_back(w);
      send_word(w, m, st, (k % 2 == 1) ? 3 : 0, 1'b0, 1'b0);
    end
    tick();

    // Restart mid-frame, partial frame LSB-first then new frame MSB-first
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    expq.push_back(8'h01);
    send_word(8'h01, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    check("restart_data", bus.out_data, 8'h01);
    tick();
    check("restart_overrun", bus.overrun, 0);
    check("restart_q", expq.size(), 0);

    // Overrun: second word dropped while first is held
    bus.out_ready = 1'b0;
    expq.push_back(8'hB4);
    send_word(8'hB4, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    send_word(8'h11, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    check("ovr_data", bus.out_data, 8'hB4);
    check("ovr_valid", bus.out_valid, 1);
    check("ovr_flag", bus.overrun, 1);
    bus.out_ready = 1'b1;
    tick();
    check("ovr_valid_drop", bus.out_valid, 0);
    check("ovr_sticky", bus.overrun, 1);

    // Reset mid-frame with a held word
    bus.out_ready = 1'b0;
    send_word(8'h5A, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    check("held_valid", bus.out_valid, 1);
    send_bit(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(1)), 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mrst_out_data", bus.out_data, 0);
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_overrun", bus.overrun, 0);
    check("mrst_parity_err", bus.parity_err, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2 * N + 2; i++) send_bit(1'($urandom_range(1)), 1'b0, 1'b1);
    tick();
    check("nostart_ignored", bus.out_valid, 0);

    // Completion in the same cycle as consumption of the held word
    bus.out_ready = 1'b0;
    expq.push_back(8'h3C);
    send_word(8'h3C, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    expq.push_back(8'hC3);
    send_word(8'hC3, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    check("swap_valid", bus.out_valid, 1);
    check("swap_data", bus.out_data, 8'hC3);
    check("swap_overrun", bus.overrun, 0);
    tick();
    check("swap_valid_clear", bus.out_valid, 0);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
    // Bad parity drops the word; good parity stores it
    bus.out_ready = 1'b1;
    send_word(8'hB4, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    check("perr_pulse", bus.parity_err, 1);
    check("perr_no_valid", bus.out_valid, 0);
    tick();
    check("perr_clear", bus.parity_err, 0);
    check("perr_no_overrun", bus.overrun, 0);
    expq.push_back(8'hB4);
    send_word(8'hB4, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    check("par_ok_data", bus.out_data, 8'hB4);
    check("par_ok_perr", bus.parity_err, 0);
`else
    check("parity_err_tied", bus.parity_err, 0);
`endif

    repeat (3) tick();
    check("q_drain", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
